// File: rtl/unidade_div_if.sv
// unidade_div_if: request/response bundle between the control unit and the
// multicycle divider.
//   start  : one-cycle division request (control unit -> divider)
//   a, b   : dividend / divisor, two's complement
//   lo, hi : quotient / remainder, registered in the divider
//   busy   : division in progress
//   done   : one-cycle pulse, lo/hi valid from this cycle
//   divby0 : one-cycle pulse, request carried a zero divisor
interface unidade_div_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic        divby0;

  modport master (output start, a, b, input lo, hi, busy, done, divby0);
  modport slave  (input start, a, b, output lo, hi, busy, done, divby0);
endinterface

// File: rtl/unidade_div.sv
// unidade_div: signed 32-bit restoring divider, 32 shift-subtract iterations
// on operand magnitudes followed by one sign-fix cycle (33 cycles start->done).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears state and all outputs
//   bus   : unidade_div_if.slave (start/a/b in, lo/hi/busy/done/divby0 out)
module unidade_div (
  input  logic           clk,
  input  logic           reset,
  unidade_div_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_n;
  logic [32:0] rem;       // partial remainder, one guard bit
  logic [31:0] q;         // dividend shifts out the top, quotient bits in the bottom
  logic [31:0] bmag;
  logic        qsign, rsign;
  logic [4:0]  cnt;

  logic [32:0] rem_sh, rem_nxt;
  logic [31:0] q_nxt;
  logic        take;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start && (bus.b != 32'd0)) state_n = CALC;
      CALC:    if (cnt == 5'd31) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem[31:0], q[31]};
    take    = (rem_sh >= {1'b0, bmag});
    rem_nxt = take ? (rem_sh - {1'b0, bmag}) : rem_sh;
    q_nxt   = {q[30:0], take};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem        <= '0;
      q          <= '0;
      bmag       <= '0;
      qsign      <= 1'b0;
      rsign      <= 1'b0;
      cnt        <= '0;
      bus.lo     <= '0;
      bus.hi     <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.divby0 <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.divby0 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.b == 32'd0) begin
              bus.divby0 <= 1'b1;
            end else begin
              q        <= mag(bus.a);
              bmag     <= mag(bus.b);
              qsign    <= bus.a[31] ^ bus.b[31];
              rsign    <= bus.a[31];
              rem      <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          bus.lo   <= qsign ? (~q + 32'd1) : q;
          bus.hi   <= rsign ? (~rem[31:0] + 32'd1) : rem[31:0];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_div.sv
module tb_unidade_div;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  unidade_div_if bus ();

  unidade_div dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive a one-cycle start; returns at the first negedge after the sampling edge.
  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // skip = negedges already spent since the first post-start negedge.
  task automatic wait_done(input string tag, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int skip);
    int lat;
    int bcnt;
    lat  = skip;
    bcnt = skip + (bus.busy ? 1 : 0);
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_busy_cycles"}, bcnt, 33);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_no_divby0"}, {31'd0, bus.divby0}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_divby0", {31'd0, bus.divby0}, 32'd0);
    reset = 1'b0;

    kick(32'd100, 32'd7);
    chk("p100_busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_done("p100_7", 32'd14, 32'd2, 0);

    // zero divisor: pulse, no busy, results held
    kick(32'd55, 32'd0);
    chk("dz_divby0", {31'd0, bus.divby0}, 32'd1);
    chk("dz_busy", {31'd0, bus.busy}, 32'd0);
    chk("dz_done", {31'd0, bus.done}, 32'd0);
    chk("dz_lo_held", bus.lo, 32'd14);
    chk("dz_hi_held", bus.hi, 32'd2);
    @(negedge clk);
    chk("dz_pulse_end", {31'd0, bus.divby0}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("dz_no_activity", seen, 0);

    kick(32'hFFFFFF9C, 32'd7);
    wait_done("m100_7", 32'hFFFFFFF2, 32'hFFFFFFFE, 0);

    kick(32'd100, 32'hFFFFFFF9);
    wait_done("p100_m7", 32'hFFFFFFF2, 32'd2, 0);

    kick(32'h80000000, 32'hFFFFFFFF);
    wait_done("minint_m1", 32'h80000000, 32'd0, 0);

    // re-pulse start mid-division with different operands
    kick(32'd50, 32'd5);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("repulse_50_5", 32'd10, 32'd0, 5);

    // need nonzero hi/lo before the abort to make the reset check meaningful
    kick(32'd100, 32'd7);
    wait_done("pre_abort", 32'd14, 32'd2, 0);
    kick(32'd77, 32'd3);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", seen, 0);

    kick(32'd9, 32'd3);
    wait_done("p9_3", 32'd3, 32'd0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/unidade_div.md
# unidade_div

Multicycle signed 32-bit divider answering the control unit's DIV request. It sits beside the ALU in the datapath. On a one-cycle `start` it latches the A/B register operands and runs a 32-iteration restoring shift-subtract. It then hands back quotient (`lo`) and remainder (`hi`) with a `done` pulse, which the control unit uses to assert `hiwrite`/`lowrite`; a zero divisor raises `divby0` instead.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  dividend, two's complement.
- `b`  in  32  divisor, two's complement.
- `lo`  out  32  quotient, registered.
- `hi`  out  32  remainder, registered.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle.
- `divby0`  out  1  one-cycle pulse; divisor was zero.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start` + `b != 0`:
  - Latch magnitudes |a| and |b|, the quotient sign (`a[31]^b[31]`) and the remainder sign (`a[31]`).
  - Clear the 33-bit partial remainder, load the counter to 0, go to CALC, raise `busy`.
- IDLE + `start` + `b == 0`:
  - Pulse `divby0` next cycle and stay in IDLE.
  - `busy` stays low, no `done`, `hi`/`lo` unchanged.
- CALC, each cycle:
  - rem = {rem[31:0], q[31]}, then q = {q[30:0], 0}.
  - If rem >= |b|: rem -= |b| and q[0] = 1.
  - Counter increments; after the 32nd iteration go to FIX.
- FIX:
  - `lo` = quotient sign ? -q : q.
  - `hi` = remainder sign ? -rem[31:0] : rem[31:0].
  - Pulse `done`, drop `busy`, return to IDLE.
- Magnitude of 0x80000000 is 0x80000000 taken as unsigned; no special-case logic.
- 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0 (wraps, no flag).
- `start` in CALC or FIX is ignored; operand changes after the latch cycle have no effect.
- `hi`/`lo` hold their last result until the next `done`.

## Timing
- Reset value of every output is 0: `lo`, `hi`, `busy`, `done`, `divby0`. State is IDLE.
- Reset asserted mid-division aborts immediately; no `done` is issued afterwards.
- `start` sampled at edge E0:
  - `busy` = 1 after E0.
  - Iterations at E1..E32.
  - FIX at E33: `hi`/`lo` updated, `done` = 1 and `busy` = 0 for the cycle after E33.
  - Total 33 cycles from the start edge to `done`.
- `divby0` is high exactly in the cycle after the sampling edge.
- `start` held high through `done`: a new division is accepted on the first IDLE edge after FIX, with no bubble required beyond that.
- `done` and `divby0` are never high together.

## Test plan
- a=100, b=7 -> 33 cycles after start: `lo`=14, `hi`=2, `done` pulses once, `busy` high for exactly 33 cycles.
- a=-100 (0xFFFFFF9C), b=7 -> `lo`=-14 (0xFFFFFFF2), `hi`=-2 (0xFFFFFFFE); a=100, b=-7 -> `lo`=-14, `hi`=2.
- a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, no `divby0`.
- b=0 with prior `hi`=2/`lo`=14 -> `divby0` pulse next cycle, `busy` stays 0, `hi`/`lo` stay 2/14, no `done`.
- `reset` asserted 10 cycles into a division -> outputs immediately 0. Then start a=9, b=3 -> `lo`=3, `hi`=0 after 33 cycles.
- `start` re-pulsed at cycle 5 with a=1, b=1 during a=50, b=5 -> ignored; result `lo`=10, `hi`=0.
